// File: rtl/ins_step_sequencer_pkg.sv
// Shared constants for the instruction step sequencer: state encodings and parameter defaults.
package ins_step_sequencer_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd3;
  localparam logic [STATE_W-1:0] ST_PAUSE = 3'd4;
  localparam logic [STATE_W-1:0] ST_HALT  = 3'd5;

  // Step index of DEF_STEP_W bits addresses DEF_NSTEP = 2**DEF_STEP_W execute steps.
  localparam int unsigned DEF_STEP_W = 5;
  localparam int unsigned DEF_NSTEP  = 1 << DEF_STEP_W;
  localparam int unsigned DEF_OPC_W  = 6;
  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_PC_INC = 4;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [5:0]  DEF_HALT_OPC = 6'b111111;

endpackage

// File: rtl/ins_step_sequencer_step_decoder.sv
// Binary step index to one-hot time-step vector; all-zero when not enabled.
module ins_step_sequencer_step_decoder #(
  parameter int unsigned STEP_W = 5
) (
  input  logic                     en,
  input  logic [STEP_W-1:0]        idx,
  output logic [(2**STEP_W)-1:0]   step
);

  always_comb begin
    step = '0;
    if (en) step[idx] = 1'b1;
  end

endmodule

// File: rtl/ins_step_sequencer.sv
// Autonomous fetch/execute sequencer: owns the PC, fetches, and walks one-hot execute steps.
module ins_step_sequencer
  import ins_step_sequencer_pkg::*;
#(
  parameter int unsigned      STEP_W   = DEF_STEP_W,
  parameter int unsigned      OPC_W    = DEF_OPC_W,
  parameter int unsigned      PC_W     = DEF_PC_W,
  parameter int unsigned      PC_INC   = DEF_PC_INC,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(DEF_RESET_PC),
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'(DEF_HALT_OPC)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_run,
  input  logic                    i_step_mode,
  input  logic                    i_step_req,
  input  logic                    i_fetch_ack,
  input  logic [OPC_W-1:0]        i_opcode,
  input  logic [STEP_W:0]         i_ins_steps,
  input  logic                    i_branch_taken,
  input  logic [PC_W-1:0]         i_branch_target,
  output logic [PC_W-1:0]         o_pc,
  output logic                    o_fetch_req,
  output logic                    o_ir_we,
  output logic [(2**STEP_W)-1:0]  o_step,
  output logic [STEP_W-1:0]       o_step_idx,
  output logic                    o_ins_done,
  output logic                    o_busy,
  output logic                    o_halted,
  output logic [31:0]             o_ins_count
);

  localparam int unsigned NSTEP = 2**STEP_W;
  localparam int unsigned LEN_W = STEP_W + 1;

  logic [STATE_W-1:0] state, state_next;
  logic [LEN_W-1:0]   len_q, len_raw, len_eff;
  logic               step_zero, last_step, halt_hit, step_en;
  logic               br_taken_q;
  logic [PC_W-1:0]    br_target_q;

  // Zero-length instructions run one step; oversize lengths clamp to the step vector width.
  always_comb begin
    len_raw = i_ins_steps;
    if (i_ins_steps == '0) len_raw = LEN_W'(1);
    else if (i_ins_steps > LEN_W'(NSTEP)) len_raw = LEN_W'(NSTEP);
  end

  assign step_zero = (o_step_idx == '0);
  assign len_eff   = step_zero ? len_raw : len_q;
  assign last_step = ({1'b0, o_step_idx} == (len_eff - LEN_W'(1)));
  assign halt_hit  = (state == ST_EXEC) && step_zero && (i_opcode == HALT_OPC);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    o_fetch_req = 1'b0;
    o_ir_we     = 1'b0;
    o_ins_done  = 1'b0;
    o_busy      = 1'b0;
    o_halted    = 1'b0;
    step_en     = 1'b0;
    case (state)
      ST_IDLE: if (i_run) state_next = ST_FETCH;
      ST_FETCH: begin
        o_fetch_req = 1'b1;
        o_busy      = 1'b1;
        o_ir_we     = i_fetch_ack;
        if (i_fetch_ack) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        o_busy  = 1'b1;
        step_en = 1'b1;
        if (halt_hit)       state_next = ST_HALT;
        else if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        o_ins_done = 1'b1;
        if (i_step_mode) state_next = ST_PAUSE;
        else if (i_run)  state_next = ST_FETCH;
        else             state_next = ST_IDLE;
      end
      ST_PAUSE: begin
        if (i_step_req)       state_next = ST_FETCH;
        else if (!i_step_mode) state_next = i_run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: o_halted = 1'b1;
      default: state_next = ST_IDLE;
    endcase
  end

  // Step counter, length latch, branch capture, PC and retire counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pc        <= RESET_PC;
      o_step_idx  <= '0;
      o_ins_count <= '0;
      len_q       <= LEN_W'(1);
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      case (state)
        ST_FETCH: if (i_fetch_ack) o_step_idx <= '0;
        ST_EXEC: begin
          if (step_zero) len_q <= len_raw;
          if (!halt_hit) begin
            if (last_step) begin
              br_taken_q  <= i_branch_taken;
              br_target_q <= i_branch_target;
            end else begin
              o_step_idx <= o_step_idx + STEP_W'(1);
            end
          end
        end
        ST_DONE: begin
          o_pc <= br_taken_q ? br_target_q : o_pc + PC_W'(PC_INC);
          if (o_ins_count != '1) o_ins_count <= o_ins_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  ins_step_sequencer_step_decoder #(.STEP_W(STEP_W)) u_step_decoder (
    .en   (step_en),
    .idx  (o_step_idx),
    .step (o_step)
  );

endmodule

// File: tb/tb_ins_step_sequencer.sv
// Scoreboard bench for ins_step_sequencer: directed instruction stream, retire monitor checks PC/count/spacing.
module tb_ins_step_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, step_mode, step_req, fetch_ack, branch_taken;
  logic [5:0]  opcode, ins_steps;
  logic [31:0] branch_target;
  logic [31:0] pc, ins_count;
  logic        fetch_req, ir_we, ins_done, busy, halted;
  logic [31:0] step;
  logic [4:0]  step_idx;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_done = 0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] model_cnt = 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ins_step_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_step_mode(step_mode), .i_step_req(step_req),
    .i_fetch_ack(fetch_ack), .i_opcode(opcode), .i_ins_steps(ins_steps),
    .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .o_pc(pc), .o_fetch_req(fetch_req), .o_ir_we(ir_we), .o_step(step), .o_step_idx(step_idx),
    .o_ins_done(ins_done), .o_busy(busy), .o_halted(halted), .o_ins_count(ins_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Retire monitor: every o_ins_done pops one expected retire.
  initial begin
    forever begin
      @(negedge clk);
      if (ins_done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", 64'(pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("retire_pc", 64'(pc), 64'(e.pc));
          check("retire_count", 64'(ins_count), 64'(e.cnt));
          if (e.gap > 0) check("retire_gap", 64'(cyc - last_done), 64'(e.gap));
        end
        last_done = cyc;
      end
    end
  end

  // Serves one fetch: waits for the request, acks after ack_wait cycles, drives the instruction.
  task automatic issue(input logic [5:0] opc, input logic [5:0] steps, input int ack_wait,
                       input logic br, input logic [31:0] tgt, input bit push,
                       input bit chk_steps, input int gap);
    int  k;
    int  len;
    exp_t e;
    for (k = 0; k < 200 && fetch_req !== 1'b1; k++) @(negedge clk);
    if (fetch_req !== 1'b1) begin
      check("fetch_timeout", 64'(fetch_req), 64'd1);
      return;
    end
    check("fetch_pc", 64'(pc), 64'(model_pc));
    repeat (ack_wait) begin
      @(negedge clk);
      check("fetch_req_held", 64'(fetch_req), 64'd1);
    end
    opcode = opc; ins_steps = steps; branch_taken = br; branch_target = tgt;
    fetch_ack = 1'b1;
    #1 check("ir_we_on_ack", 64'(ir_we), 64'd1);
    if (push) begin
      e.pc = model_pc; e.cnt = model_cnt; e.gap = gap;
      sb.push_back(e);
      model_pc  = br ? tgt : model_pc + 32'd4;
      model_cnt = model_cnt + 32'd1;
    end
    @(negedge clk);
    fetch_ack = 1'b0;
    #1 check("ir_we_single", 64'(ir_we), 64'd0);
    if (chk_steps) begin
      len = (steps == 0) ? 1 : (steps > 32) ? 32 : int'(steps);
      for (int i = 0; i < len; i++) begin
        check("step_onehot", 64'(step), 64'(32'd1 << i));
        check("step_idx", 64'(step_idx), 64'(i));
        @(negedge clk);
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step_mode = 1'b0; step_req = 1'b0; fetch_ack = 1'b0;
    opcode = 6'd1; ins_steps = 6'd1; branch_taken = 1'b0; branch_target = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_pc", 64'(pc), 64'h0);
    check("rst_step", 64'(step), 64'h0);
    check("rst_flags", 64'({fetch_req, ir_we, ins_done, busy, halted}), 64'h0);
    check("rst_count", 64'(ins_count), 64'h0);
    check("rst_step_idx", 64'(step_idx), 64'h0);
    rst = 1'b0;
    run = 1'b1;

    // Delayed ack, 4-step instruction with step vector walk.
    issue(6'd1, 6'd4, 2, 1'b0, 32'h0, 1'b1, 1'b1, 0);
    // Back-to-back 3, 5, 0(->1) and 40(->32) steps with immediate ack.
    issue(6'd1, 6'd3,  0, 1'b0, 32'h0, 1'b1, 1'b0, 5);
    issue(6'd1, 6'd5,  0, 1'b0, 32'h0, 1'b1, 1'b0, 7);
    issue(6'd1, 6'd0,  0, 1'b0, 32'h0, 1'b1, 1'b0, 3);
    issue(6'd1, 6'd40, 0, 1'b0, 32'h0, 1'b1, 1'b0, 34);
    // Branch redirect, then PC wrap from FFFFFFFC.
    issue(6'd1, 6'd2, 0, 1'b1, 32'h40,        1'b1, 1'b0, 0);
    issue(6'd1, 6'd1, 0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 0);
    issue(6'd1, 6'd1, 0, 1'b0, 32'h0,         1'b1, 1'b0, 0);
    issue(6'd1, 6'd1, 1, 1'b0, 32'h0,         1'b1, 1'b0, 0);
    drain();

    // Single-step mode: pause after retire, one step_req releases one instruction.
    step_mode = 1'b1;
    issue(6'd1, 6'd2, 0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    drain();
    repeat (4) @(negedge clk);
    check("pause_busy", 64'(busy), 64'd0);
    check("pause_no_fetch", 64'(fetch_req), 64'd0);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    issue(6'd1, 6'd4, 0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    check("pause_again_busy", 64'(busy), 64'd0);
    check("exec_step_req_ignored", 64'(fetch_req), 64'd0);
    step_mode = 1'b0;
    issue(6'd1, 6'd1, 0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    drain();

    // Halt opcode: no retire, PC and count frozen, only reset releases.
    issue(6'h3F, 6'd3, 0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("halted", 64'(halted), 64'd1);
    check("halt_step_zero", 64'(step), 64'd0);
    check("halt_busy", 64'(busy), 64'd0);
    check("halt_pc", 64'(pc), 64'(model_pc));
    check("halt_count", 64'(ins_count), 64'(model_cnt));
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (4) @(negedge clk);
    check("halt_sticky", 64'({halted, fetch_req, ins_done}), 64'b100);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    check("halt_rst_pc", 64'(pc), 64'h0);
    check("halt_rst_halted", 64'(halted), 64'd0);
    check("halt_rst_count", 64'(ins_count), 64'd0);
    rst = 1'b0;
    model_pc = 32'h0; model_cnt = 32'h0;

    // Reset in the middle of EXEC step 2.
    run = 1'b1;
    issue(6'd1, 6'd2, 0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    issue(6'd1, 6'd5, 0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_step2", 64'(step), 64'h4);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    check("mid_rst_step", 64'(step), 64'h0);
    check("mid_rst_pc", 64'(pc), 64'h0);
    check("mid_rst_count", 64'(ins_count), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    model_pc = 32'h0; model_cnt = 32'h0;

    // Run dropped at step 1: the instruction still retires, then the sequencer idles.
    run = 1'b1;
    issue(6'd1, 6'd4, 0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    @(negedge clk);
    run = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("run_drop_idle", 64'({busy, fetch_req}), 64'b00);
    check("run_drop_pc", 64'(pc), 64'(model_pc));
    check("run_drop_count", 64'(ins_count), 64'(model_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
